rsff_excite_ctrl: RTL and testbench
===================================

Name: rsff_excite_ctrl

Overview:
- Drives the R/S inputs of an external RS flip-flop so that it reaches a requested state, then confirms the result from its Q/nQ feedback.
- It is the stimulus end of the RS flip-flop interface: it accepts target-state requests over a valid/ready handshake.
- It generates only legal excitation; R=S=1 is never driven.
- It reports done, timeout, or illegal-output errors to the requester.

Parameters:
- HOLD_CYC, 2, cycles R or S stays asserted per update, range 1..15.
- TIMEOUT_CYC, 12, maximum WAIT cycles before a timeout error, range 1..255.
- ILLEGAL_CYC, 3, consecutive synchronized Q==nQ samples in WAIT that raise an illegal error, range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_d  in  1  target Q value.
- req_hold  in  1  hold request: drive R=S=0 and confirm that Q/nQ are legal; req_d is ignored.
- req_ready  out  1  high only in IDLE.
- R  out  1  reset excitation to the flip-flop, registered.
- S  out  1  set excitation to the flip-flop, registered.
- Q  in  1  flip-flop output, asynchronous to clk.
- nQ  in  1  flip-flop complement output, asynchronous to clk.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on failure.
- err_code  out  2  meaning: 00 none, 01 timeout, 10 illegal Q==nQ; valid while err=1, otherwise 00.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; R=0, S=0, done=0, err=0, err_code=00, busy=0; both sync stages=0; counters=0. On reset release req_ready=1.
- Reset mid-operation: R and S drop to 0 immediately, without waiting for a clock edge. Any in-flight request is discarded with no done and no err.
- Synchronization: Q and nQ each pass through a 2-flop synchronizer; qs and nqs denote the second-stage values. All decisions use qs/nqs only.
- Handshake: a request is accepted on the clk edge where req_valid=1 and req_ready=1. The block latches req_d and req_hold at that edge. Requests presented while busy are not accepted.
- States:
  - IDLE: R=S=0. On acceptance:
    - hold request -> WAIT.
    - qs==req_d and nqs==~req_d -> DONE (already in target state; no excitation).
    - otherwise -> DRIVE.
  - DRIVE: S=1,R=0 when target=1; R=1,S=0 when target=0. Stays for exactly HOLD_CYC cycles, then -> WAIT with R=S=0.
  - WAIT: R=S=0. The timeout counter counts from 1 each cycle in WAIT.
    - Success when qs==target and nqs==~target. For hold requests, success is any qs!=nqs. Success -> DONE.
    - Illegal counter increments while qs==nqs and clears otherwise. When it reaches ILLEGAL_CYC -> ERR with code 10.
    - When the timeout counter reaches TIMEOUT_CYC without success -> ERR with code 01.
    - If success and a limit occur in the same cycle, success wins. If both limits occur in the same cycle, 10 wins.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: err=1 with err_code for one cycle -> IDLE.
- Invariant: R&S==0 on every cycle, including reset.
- Latency, responsive flip-flop that settles within 1 cycle of excitation: acceptance -> DONE pulse = 1 + HOLD_CYC + 3 cycles (2 synchronizer cycles + 1 compare cycle). Already-in-state: the done pulse appears 1 cycle after acceptance.
- busy is high in DRIVE, WAIT, DONE and ERR. req_ready=~busy.

Optional Feature:
- Macro RSF_STICKY_ERR_EN.
- Defined:
  - An extra input port err_clr (1 bit) is present.
  - After ERR the FSM goes to LOCK instead of IDLE. In LOCK: R=S=0, req_ready=0, busy=1, and err_code holds its value. err pulses only once, on entry.
  - err_clr=1 in LOCK -> IDLE and err_code=00 on the next edge. err_clr is ignored in all other states.
- Undefined: no err_clr port, no LOCK state; ERR returns directly to IDLE.

Test Plan:
- Reset: rst_n=0 mid-DRIVE with S=1 -> S=0 immediately; after release IDLE, req_ready=1, no done or err.
- Set: flip-flop model at Q=0, request req_d=1 -> S=1 for 2 cycles, R never 1; done pulses 6 cycles after acceptance.
- Already set: Q=1, request req_d=1 -> R=S=0 throughout; done 1 cycle after acceptance.
- Timeout: model ignores excitation with Q=0, nQ=1; request req_d=1 -> err=1, err_code=01 after 12 WAIT cycles; returns to IDLE.
- Illegal: model forces Q=nQ=0; hold request -> err_code=10 after 3 consecutive samples; R&S=0 checked every cycle.
- With RSF_STICKY_ERR_EN: after the timeout case, req_ready stays 0 for 20 cycles; an err_clr pulse -> req_ready=1, err_code=00.

Source files
------------

// File: rtl/rsff_excite_ctrl.sv
// Excitation controller for an external RS flip-flop. It drives only legal R/S pulses, then
// confirms the result from synchronized Q/nQ feedback. Define RSF_STICKY_ERR_EN for sticky errors.
module rsff_excite_ctrl #(
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned TIMEOUT_CYC = 12,
  parameter int unsigned ILLEGAL_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_d,
  input  logic       req_hold,
`ifdef RSF_STICKY_ERR_EN
  input  logic       err_clr,
`endif
  output logic       req_ready,
  output logic       R,
  output logic       S,
  input  logic       Q,
  input  logic       nQ,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [3:0] HoldMax = 4'(HOLD_CYC);
  localparam logic [7:0] TmoMax  = 8'(TIMEOUT_CYC);
  localparam logic [2:0] IllMax  = 3'(ILLEGAL_CYC);

  localparam logic [1:0] CodeNone = 2'b00;
  localparam logic [1:0] CodeTmo  = 2'b01;
  localparam logic [1:0] CodeIll  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StDone,
`ifdef RSF_STICKY_ERR_EN
    StLock,
`endif
    StErr
  } state_e;

  state_e     state_q;
  logic       q_s1, q_s2, nq_s1, nq_s2;
  logic       tgt_q, hold_q;
  logic       hit_q, legal_q;
  logic [3:0] hold_cnt_q;
  logic [7:0] tmo_q, tmo_nxt;
  logic [2:0] ill_q, ill_nxt;
  logic       wait_ok;

  assign req_ready = ~busy;

  // Compare results are registered one cycle after the synchronizer.
  always_comb begin
    wait_ok = hold_q ? legal_q : hit_q;
    ill_nxt = legal_q ? 3'd0 : ill_q + 3'd1;
    tmo_nxt = tmo_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      q_s1       <= 1'b0;
      q_s2       <= 1'b0;
      nq_s1      <= 1'b0;
      nq_s2      <= 1'b0;
      tgt_q      <= 1'b0;
      hold_q     <= 1'b0;
      hit_q      <= 1'b0;
      legal_q    <= 1'b0;
      hold_cnt_q <= 4'd0;
      tmo_q      <= 8'd0;
      ill_q      <= 3'd0;
      R          <= 1'b0;
      S          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= CodeNone;
    end else begin
      q_s1     <= Q;
      q_s2     <= q_s1;
      nq_s1    <= nQ;
      nq_s2    <= nq_s1;
      hit_q    <= (q_s2 == tgt_q) && (nq_s2 != tgt_q);
      legal_q  <= (q_s2 != nq_s2);
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= CodeNone;

      unique case (state_q)
        StIdle: begin
          R    <= 1'b0;
          S    <= 1'b0;
          busy <= 1'b0;
          if (req_valid) begin
            tgt_q  <= req_d;
            hold_q <= req_hold;
            busy   <= 1'b1;
            tmo_q  <= 8'd0;
            ill_q  <= 3'd0;
            if (req_hold) begin
              state_q <= StWait;
            end else if ((q_s2 == req_d) && (nq_s2 != req_d)) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q    <= StDrive;
              S          <= req_d;
              R          <= ~req_d;
              hold_cnt_q <= 4'd1;
            end
          end
        end

        StDrive: begin
          if (hold_cnt_q == HoldMax) begin
            R       <= 1'b0;
            S       <= 1'b0;
            state_q <= StWait;
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end

        // Success beats both limits; the illegal limit beats the timeout.
        StWait: begin
          R     <= 1'b0;
          S     <= 1'b0;
          tmo_q <= tmo_nxt;
          ill_q <= ill_nxt;
          if (wait_ok) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else if (ill_nxt == IllMax) begin
            state_q  <= StErr;
            err      <= 1'b1;
            err_code <= CodeIll;
          end else if (tmo_nxt == TmoMax) begin
            state_q  <= StErr;
            err      <= 1'b1;
            err_code <= CodeTmo;
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end

        StErr: begin
`ifdef RSF_STICKY_ERR_EN
          state_q  <= StLock;
          err_code <= err_code;
`else
          state_q <= StIdle;
          busy    <= 1'b0;
`endif
        end

`ifdef RSF_STICKY_ERR_EN
        StLock: begin
          R        <= 1'b0;
          S        <= 1'b0;
          err_code <= err_code;
          if (err_clr) begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            err_code <= CodeNone;
          end
        end
`endif

        default: begin
          state_q <= StIdle;
          R       <= 1'b0;
          S       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsff_excite_ctrl.sv
// Randomized bench for rsff_excite_ctrl with a behavioural flip-flop and an outcome model.
// Covers the RSF_STICKY_ERR_EN lock path when that macro is defined.
module tb_rsff_excite_ctrl;

  localparam int HOLD  = 2;
  localparam int TMO   = 12;
  localparam int ILL   = 3;
  localparam int LIMIT = HOLD + TMO + 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_d = 1'b0;
  logic       req_hold = 1'b0;
  logic       err_clr = 1'b0;
  logic       req_ready, R, S, Q, nQ, busy, done, err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Flip-flop model: 0 responsive, 1 ignores excitation, 2 forced Q=nQ=0.
  int   mode = 0;
  logic ff = 1'b0;
  logic preset_en = 1'b0;
  logic preset_val = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset_en) ff <= preset_val;
    else if (mode == 0 && S && !R) ff <= 1'b1;
    else if (mode == 0 && R && !S) ff <= 1'b0;
  end

  assign Q  = (mode == 2) ? 1'b0 : ff;
  assign nQ = (mode == 2) ? 1'b0 : ~ff;

  rsff_excite_ctrl #(
    .HOLD_CYC   (HOLD),
    .TIMEOUT_CYC(TMO),
    .ILLEGAL_CYC(ILL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_d    (req_d),
    .req_hold (req_hold),
`ifdef RSF_STICKY_ERR_EN
    .err_clr  (err_clr),
`endif
    .req_ready(req_ready),
    .R        (R),
    .S        (S),
    .Q        (Q),
    .nQ       (nQ),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic setup_ff(input int m, input logic q0);
    @(negedge clk);
    mode       = m;
    preset_en  = 1'b1;
    preset_val = q0;
    @(negedge clk);
    preset_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // One request; expected outcome, latency and excitation come from the request rules.
  task automatic run_req(input logic d, input logic hold, input int m, input logic q0);
    bit legal, already, seen, is_err;
    int exp_err, exp_code, exp_lat, exp_s, exp_r, k, s_cnt, r_cnt;
    setup_ff(m, q0);
    check_eq("ready_before_req", req_ready, 1);
    legal   = (m != 2);
    already = legal && (q0 == d);
    exp_s   = 0;
    exp_r   = 0;
    if (hold) begin
      if (!legal) begin exp_err = 1; exp_code = 2; exp_lat = ILL; end
      else        begin exp_err = 0; exp_code = 0; exp_lat = 1;   end
    end else if (already) begin
      exp_err = 0; exp_code = 0; exp_lat = 0;
    end else begin
      if (d) exp_s = HOLD;
      else   exp_r = HOLD;
      if (!legal)       begin exp_err = 1; exp_code = 2; exp_lat = HOLD + ILL; end
      else if (m == 0)  begin exp_err = 0; exp_code = 0; exp_lat = HOLD + 3;   end
      else              begin exp_err = 1; exp_code = 1; exp_lat = HOLD + TMO; end
    end

    req_valid = 1'b1;
    req_d     = d;
    req_hold  = hold;
    @(posedge clk);
    #1;
    seen   = 0;
    is_err = 0;
    k      = 0;
    s_cnt  = 0;
    r_cnt  = 0;
    while (!seen && k < LIMIT) begin
      check_eq("rs_exclusive", R & S, 0);
      s_cnt += int'(S);
      r_cnt += int'(R);
      if (done || err) begin
        seen      = 1;
        is_err    = err;
        req_valid = 1'b0;
        check_eq("pulse_is_err", int'(err), exp_err);
        check_eq("err_code", err_code, exp_code);
        check_eq("pulse_latency", k, exp_lat);
      end else begin
        // Requests while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_d     = 1'($urandom);
        req_hold  = 1'($urandom);
        @(posedge clk);
        #1;
        k++;
      end
    end
    req_valid = 1'b0;
    check_eq("pulse_seen", int'(seen), 1);
    check_eq("s_cycles", s_cnt, exp_s);
    check_eq("r_cycles", r_cnt, exp_r);

`ifdef RSF_STICKY_ERR_EN
    if (is_err) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        check_eq("lock_ready", req_ready, 0);
        check_eq("lock_rs", int'(R | S), 0);
      end
      check_eq("lock_code", err_code, exp_code);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
`else
    @(posedge clk);
    #1;
`endif
    check_eq("idle_ready", req_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_pulses", int'(done | err), 0);
    check_eq("idle_code", err_code, 0);
  endtask

  task automatic reset_mid_drive();
    setup_ff(0, 1'b0);
    req_valid = 1'b1;
    req_d     = 1'b1;
    req_hold  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("mid_drive_s", S, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_s", S, 0);
    check_eq("async_rst_r", R, 0);
    check_eq("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_ready", req_ready, 1);
      check_eq("post_rst_pulses", int'(done | err), 0);
    end
  endtask

  initial begin
    int m;
    #12;
    check_eq("rst_r", R, 0);
    check_eq("rst_s", S, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_code", err_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_ready", req_ready, 1);

    run_req(1'b1, 1'b0, 0, 1'b0);  // set from Q=0
    run_req(1'b1, 1'b0, 0, 1'b1);  // already set
    run_req(1'b1, 1'b0, 1, 1'b0);  // timeout
    run_req(1'b0, 1'b1, 2, 1'b0);  // illegal on hold request
    run_req(1'b0, 1'b0, 0, 1'b1);  // reset from Q=1
    run_req(1'b0, 1'b1, 0, 1'b1);  // legal hold
    reset_mid_drive();

    for (int i = 0; i < 40; i++) begin
      m = int'($urandom_range(0, 3));
      if (m == 3) m = 0;
      run_req(1'($urandom), ($urandom_range(0, 3) == 0), m, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
